// File: rtl/ctrl_sequencer.sv
// Fetch/decode/execute sequencer for ADD, ADDI, BEQ, BNE; owns the PC and drives ALU controls.
// Latency: 3 cycles per instruction (FETCH, DECODE, EXEC) plus one cycle per imem_valid stall.
// Backpressure: FETCH holds imem_req and pc until imem_valid; CTRL_SEQ_INSTRET_EN enables instret.
module ctrl_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] pc,
  input  logic                  imem_valid,
  input  logic [DATA_WIDTH-1:0] instr,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [4:0]            rd,
  output logic                  reg_we,
  output logic [2:0]            ALUctrl,
  output logic                  ALUsrc,
  output logic [DATA_WIDTH-1:0] ImmOp,
  input  logic                  EQ,
  output logic                  halted,
  output logic [31:0]           instret
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] ir;

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic                  is_add;
  logic                  is_addi;
  logic                  is_beq;
  logic                  is_bne;
  logic                  legal;
  logic [DATA_WIDTH-1:0] imm_i;
  logic [DATA_WIDTH-1:0] imm_b;
  logic [DATA_WIDTH-1:0] br_target;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic                  taken;
  logic                  misaligned;

  // Register addresses come straight from IR so the regfile can read during DECODE.
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign rd     = ir[11:7];

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];

  assign is_add  = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
  assign is_addi = (opcode == 7'b0010011) && (funct3 == 3'b000);
  assign is_beq  = (opcode == 7'b1100011) && (funct3 == 3'b000);
  assign is_bne  = (opcode == 7'b1100011) && (funct3 == 3'b001);
  assign legal   = is_add || is_addi || is_beq || is_bne;

  assign imm_i = {{(DATA_WIDTH-12){ir[31]}}, ir[31:20]};
  assign imm_b = {{(DATA_WIDTH-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

  // Both candidate next-PCs wrap naturally at the datapath width.
  assign br_target  = pc + imm_b;
  assign pc_plus4   = pc + DATA_WIDTH'(4);
  assign taken      = (is_beq && EQ) || (is_bne && !EQ);
  assign misaligned = taken && (br_target[1:0] != 2'b00);

  // Sequencer FSM; every control output is registered and set on entry to the state that owns it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      ir       <= '0;
      imem_req <= 1'b0;
      reg_we   <= 1'b0;
      ALUctrl  <= 3'b000;
      ALUsrc   <= 1'b0;
      ImmOp    <= '0;
      halted   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_valid) begin
            ir       <= instr;
            state    <= DECODE;
            imem_req <= 1'b0;
          end
        end
        DECODE: begin
          if (legal) begin
            state   <= EXEC;
            ALUctrl <= 3'b000;
            ALUsrc  <= is_addi;
            ImmOp   <= is_addi ? imm_i : '0;
            // Writes to x0 are suppressed here so the regfile never sees them.
            reg_we  <= (is_add || is_addi) && (ir[11:7] != 5'd0);
          end else begin
            state  <= HALT;
            halted <= 1'b1;
          end
        end
        EXEC: begin
          reg_we  <= 1'b0;
          ALUctrl <= 3'b000;
          ALUsrc  <= 1'b0;
          ImmOp   <= '0;
          if (misaligned) begin
            // Leave pc on the trapping branch for post-mortem.
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            pc       <= taken ? br_target : pc_plus4;
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state  <= HALT;
          halted <= 1'b1;
        end
      endcase
    end
  end

`ifdef CTRL_SEQ_INSTRET_EN
  logic retire;

  // An instruction retires when EXEC completes without a misaligned-branch trap.
  assign retire = (state == EXEC) && !misaligned;

  // Retired-instruction counter, wrapping at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret <= 32'd0;
    end else if (retire) begin
      instret <= instret + 32'd1;
    end
  end
`else
  assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Randomized bench for ctrl_sequencer: instruction-level model predicts every cycle's outputs.
// Latency: model walks FETCH (plus stalls), DECODE, EXEC per instruction.
// Backpressure: imem_valid stalls are randomized; traps and mid-fetch resets are exercised.
module tb_ctrl_sequencer;

  localparam int K_ADD  = 0;
  localparam int K_ADDI = 1;
  localparam int K_BEQ  = 2;
  localparam int K_BNE  = 3;
  localparam int K_ILL  = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;
`ifdef CTRL_SEQ_INSTRET_EN
  localparam bit INST_EN = 1'b1;
`else
  localparam bit INST_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] word;
    int          kind;
    logic [31:0] imm;
  } ins_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] pc;
  logic        imem_valid;
  logic [31:0] instr;
  logic [4:0]  rs1, rs2, rd;
  logic        reg_we;
  logic [2:0]  ALUctrl;
  logic        ALUsrc;
  logic [31:0] ImmOp;
  logic        EQ;
  logic        halted;
  logic [31:0] instret;

  always #5 clk = ~clk;

  ctrl_sequencer dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .pc(pc),
    .imem_valid(imem_valid), .instr(instr),
    .rs1(rs1), .rs2(rs2), .rd(rd), .reg_we(reg_we),
    .ALUctrl(ALUctrl), .ALUsrc(ALUsrc), .ImmOp(ImmOp),
    .EQ(EQ), .halted(halted), .instret(instret)
  );

  int checks = 0;
  int errors = 0;

  // Expected outputs for the current cycle and the architectural model state.
  logic        e_on = 1'b0;
  logic        e_req, e_we, e_src, e_halt;
  logic [2:0]  e_ctrl;
  logic [31:0] e_pc, e_imm, e_inst;
  logic [4:0]  e_rs1, e_rs2, e_rd;
  logic [31:0] mpc, minst, mir;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every negedge, DUT outputs against the model's expectation.
  always @(negedge clk) begin
    if (e_on) begin
      chk("imem_req", 32'(imem_req), 32'(e_req));
      chk("pc",       pc,            e_pc);
      chk("reg_we",   32'(reg_we),   32'(e_we));
      chk("ALUctrl",  32'(ALUctrl),  32'(e_ctrl));
      chk("ALUsrc",   32'(ALUsrc),   32'(e_src));
      chk("ImmOp",    ImmOp,         e_imm);
      chk("halted",   32'(halted),   32'(e_halt));
      chk("instret",  instret,       e_inst);
      chk("rs1",      32'(rs1),      32'(e_rs1));
      chk("rs2",      32'(rs2),      32'(e_rs2));
      chk("rd",       32'(rd),       32'(e_rd));
    end
  end

  // Baseline expectation: no ALU controls, pc/instret from the model, fields from the held word.
  task automatic base_exp(input logic req, input logic hlt);
    e_on   = 1'b1;
    e_req  = req;
    e_halt = hlt;
    e_pc   = mpc;
    e_we   = 1'b0;
    e_ctrl = 3'b000;
    e_src  = 1'b0;
    e_imm  = 32'd0;
    e_inst = INST_EN ? minst : 32'd0;
    e_rs1  = mir[19:15];
    e_rs2  = mir[24:20];
    e_rd   = mir[11:7];
  endtask

  function automatic logic [31:0] enc_b(input logic [12:0] b, input logic [2:0] f3,
                                        input logic [4:0] r1, input logic [4:0] r2);
    return {b[12], b[10:5], r2, r1, f3, b[4:1], b[11], 7'b1100011};
  endfunction

  function automatic ins_t mk(input logic [31:0] w, input int k, input logic [31:0] im);
    ins_t t;
    t.word = w; t.kind = k; t.imm = im;
    return t;
  endfunction

  function automatic ins_t gen(input int kind);
    ins_t        t;
    logic [4:0]  r_d, r_1, r_2;
    logic [11:0] i12;
    logic [12:0] b;
    logic [31:0] w;
    r_d = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    r_1 = 5'($urandom);
    r_2 = 5'($urandom);
    t.kind = kind;
    t.imm  = 32'd0;
    case (kind)
      K_ADD:  t.word = {7'b0000000, r_2, r_1, 3'b000, r_d, 7'b0110011};
      K_ADDI: begin
        i12    = 12'($urandom);
        t.word = {i12, r_1, 3'b000, r_d, 7'b0010011};
        t.imm  = {{20{i12[11]}}, i12};
      end
      K_BEQ, K_BNE: begin
        b = 13'($urandom) & 13'h1FFC;
        if ($urandom_range(0, 7) == 0) b[1] = 1'b1;
        t.word = enc_b(b, (kind == K_BNE) ? 3'b001 : 3'b000, r_1, r_2);
        t.imm  = {{19{b[12]}}, b};
      end
      default: begin
        case ($urandom_range(0, 3))
          0: begin w = $urandom; w[6:0] = 7'b0000011; t.word = w; end
          1: t.word = {7'b0000001, r_2, r_1, 3'b000, r_d, 7'b0110011};
          2: t.word = {12'($urandom), r_1, 3'($urandom_range(1, 7)), r_d, 7'b0010011};
          default: t.word = {7'($urandom), r_2, r_1, 3'($urandom_range(2, 7)), 5'($urandom), 7'b1100011};
        endcase
      end
    endcase
    return t;
  endfunction

  task automatic halt_cycles();
    repeat (3) begin
      @(posedge clk); #1;
      imem_valid = 1'($urandom);
      instr      = $urandom;
      base_exp(1'b0, 1'b1);
    end
  endtask

  // Reset asserted 1 ns after an edge; the async reset must show on outputs immediately.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    imem_valid = 1'($urandom);
    mpc = RPC; minst = 32'd0; mir = 32'd0;
    base_exp(1'b0, 1'b0);
    @(posedge clk); #1;
    base_exp(1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    base_exp(1'b0, 1'b0);
  endtask

  // One instruction from its first FETCH cycle; returns positioned inside EXEC or after the trap.
  task automatic run_instr(input ins_t t, input logic eq, input int dly, output bit trapped);
    logic        tk;
    logic [31:0] nxt;
    trapped = 1'b0;
    for (int i = 0; i <= dly; i++) begin
      @(posedge clk); #1;
      imem_valid = (i == dly);
      instr      = (i == dly) ? t.word : $urandom;
      EQ         = 1'($urandom);
      base_exp(1'b1, 1'b0);
    end
    @(posedge clk); #1;
    mir        = t.word;
    imem_valid = 1'($urandom);
    instr      = $urandom;
    base_exp(1'b0, 1'b0);
    if (t.kind == K_ILL) begin
      trapped = 1'b1;
      halt_cycles();
      return;
    end
    @(posedge clk); #1;
    EQ         = eq;
    imem_valid = 1'($urandom);
    instr      = $urandom;
    base_exp(1'b0, 1'b0);
    e_src = (t.kind == K_ADDI);
    e_imm = (t.kind == K_ADDI) ? t.imm : 32'd0;
    e_we  = ((t.kind == K_ADD) || (t.kind == K_ADDI)) && (t.word[11:7] != 5'd0);
    tk  = ((t.kind == K_BEQ) && eq) || ((t.kind == K_BNE) && !eq);
    nxt = tk ? (mpc + t.imm) : (mpc + 32'd4);
    if (tk && (nxt[1:0] != 2'b00)) begin
      trapped = 1'b1;
      #1;
      halt_cycles();
    end else begin
      mpc   = nxt;
      minst = minst + 32'd1;
    end
  endtask

  initial begin
    bit   tr;
    ins_t t;
    int   r;
    rst = 1'b1; imem_valid = 1'b0; instr = 32'd0; EQ = 1'b0;
    mpc = RPC; minst = 32'd0; mir = 32'd0;
    do_reset();

    // Directed walk through the documented examples.
    run_instr(mk(32'hFFD0_0293, K_ADDI, 32'hFFFF_FFFD), 1'b0, 0, tr);
    #1;
    chk("lit_addi_immop", ImmOp, 32'hFFFF_FFFD);
    chk("lit_addi_src", 32'(ALUsrc), 32'd1);
    chk("lit_addi_we", 32'(reg_we), 32'd1);
    chk("lit_addi_rd", 32'(rd), 32'd5);
    chk("lit_model_pc4", mpc, 32'h4);
    run_instr(mk(32'h0020_8033, K_ADD, 32'd0), 1'b0, 3, tr);
    #1;
    chk("lit_add_we", 32'(reg_we), 32'd0);
    chk("lit_add_instret", instret, INST_EN ? 32'd1 : 32'd0);
    repeat (2) run_instr(mk(32'h0010_8093, K_ADDI, 32'd1), 1'b0, 0, tr);
    chk("lit_model_pc10", mpc, 32'h10);
    run_instr(mk(32'hFE20_8CE3, K_BEQ, 32'hFFFF_FFF8), 1'b1, 0, tr);
    chk("lit_beq_taken", mpc, 32'h8);
    repeat (2) run_instr(mk(32'h0010_8093, K_ADDI, 32'd1), 1'b0, 1, tr);
    run_instr(mk(32'hFE20_8CE3, K_BEQ, 32'hFFFF_FFF8), 1'b0, 0, tr);
    chk("lit_beq_fall", mpc, 32'h14);
    run_instr(mk(32'hFE20_9CE3, K_BNE, 32'hFFFF_FFF8), 1'b0, 0, tr);
    chk("lit_bne_taken", mpc, 32'hC);

    // Illegal word at 0x20 traps with pc parked on it.
    do_reset();
    repeat (8) run_instr(gen(K_ADDI), 1'b0, 0, tr);
    run_instr(mk(32'h0000_0000, K_ILL, 32'd0), 1'b0, 0, tr);
    #1;
    chk("lit_ill_pc", pc, 32'h20);
    chk("lit_ill_halted", 32'(halted), 32'd1);
    chk("lit_ill_req", 32'(imem_req), 32'd0);

    // Taken branch to a target with bit 1 set traps without moving pc.
    do_reset();
    run_instr(mk(enc_b(13'd6, 3'b000, 5'd1, 5'd2), K_BEQ, 32'd6), 1'b1, 0, tr);
    #1;
    chk("lit_mis_pc", pc, 32'h0);
    chk("lit_mis_halted", 32'(halted), 32'd1);
    chk("lit_mis_instret", instret, 32'd0);

    // Reset during a stalled fetch abandons it and refetches from RESET_PC.
    do_reset();
    run_instr(gen(K_ADD), 1'b0, 0, tr);
    @(posedge clk); #1;
    imem_valid = 1'b0;
    base_exp(1'b1, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    mpc = RPC; minst = 32'd0; mir = 32'd0;
    base_exp(1'b0, 1'b0);
    #1;
    chk("lit_rst_req", 32'(imem_req), 32'd0);
    chk("lit_rst_pc", pc, RPC);
    @(posedge clk); #1;
    base_exp(1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    base_exp(1'b0, 1'b0);
    run_instr(gen(K_ADDI), 1'b0, 0, tr);

    // Randomized instruction stream with stalls, traps and occasional mid-fetch resets.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 19);
      if (r == 0)       t = gen(K_ILL);
      else if (r <= 6)  t = gen(K_ADD);
      else if (r <= 12) t = gen(K_ADDI);
      else if (r <= 16) t = gen(K_BEQ);
      else              t = gen(K_BNE);
      if ($urandom_range(0, 40) == 0) begin
        @(posedge clk); #1;
        imem_valid = 1'b0;
        base_exp(1'b1, 1'b0);
        do_reset();
      end
      run_instr(t, 1'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, tr);
      if (tr) do_reset();
    end

    @(posedge clk); #1;
    e_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Multi-cycle fetch/decode/execute sequencer that drives the ALU's operand-select, immediate and operation-control inputs and consumes its `EQ` flag to resolve branches. It sits between instruction memory and the register-file/ALU datapath. It owns the program counter, and it decodes a reduced subset: ADD, ADDI, BEQ, BNE. Any other encoding halts the core.

## Interface
- `DATA_WIDTH`, 32, datapath/PC/instruction width
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `imem_req` out 1: fetch request, `pc` valid while high
- `pc` out DATA_WIDTH: current instruction address
- `imem_valid` in 1: instruction word valid this cycle
- `instr` in DATA_WIDTH: instruction word, sampled when `imem_req && imem_valid`
- `rs1`, `rs2`, `rd` out 5 each: register-file addresses, IR[19:15], IR[24:20], IR[11:7]
- `reg_we` out 1: register-file write enable for the ALU result
- `ALUctrl` out 3: ALU operation, always 3'b000 (add) for legal instructions
- `ALUsrc` out 1: 1 selects `ImmOp` as ALU operand 2
- `ImmOp` out DATA_WIDTH: sign-extended I-immediate for ADDI, else 0
- `EQ` in 1: ALU operand equality, sampled in EXEC
- `halted` out 1: sticky trap indicator
- `instret` out 32: retired-instruction count (see Configuration)

## Operation
- States: IDLE, FETCH, DECODE, EXEC, HALT. Reset enters IDLE.
- IDLE -> FETCH unconditionally.
- FETCH: `imem_req`=1. Hold until `imem_valid`; on `imem_valid`, latch `instr` into IR and go to DECODE. `imem_valid` is ignored in all other states.
- DECODE: classify IR.
  - Legal -> EXEC.
  - Illegal -> HALT.
  - Legal set: ADD (opcode 0110011, f3 000, f7 0000000), ADDI (0010011, f3 000), BEQ (1100011, f3 000), BNE (1100011, f3 001).
- EXEC: outputs are driven from IR. Then go to FETCH, with the PC updated as below.
  - ADD: `ALUsrc`=0, `reg_we`=1.
  - ADDI: `ALUsrc`=1, `ImmOp`=sext(IR[31:20]), `reg_we`=1.
  - BEQ/BNE: `ALUsrc`=0, `reg_we`=0. Taken = `EQ` for BEQ, `!EQ` for BNE.
  - `reg_we` is forced to 0 when `rd`==0.
- PC update in EXEC:
  - Taken branch: pc <= pc + sext(B-imm, 13 bits), modulo 2^32.
  - Otherwise: pc <= pc + 4, modulo 2^32 (wrap from 32'hFFFF_FFFC to 0).
- Misaligned taken-branch target (target[1:0] != 0): PC is not updated and the FSM goes to HALT.
- HALT:
  - `halted`=1, all other control outputs 0.
  - Left only by reset.
  - `pc` holds the address of the trapping instruction.
- `rs1`/`rs2`/`rd` are combinational from IR and valid from DECODE onward. `ALUctrl`, `ALUsrc`, `ImmOp` and `reg_we` are 0 outside EXEC.

## Timing
- Reset values: `pc`=RESET_PC, IR=0, `imem_req`=0, `reg_we`=0, `ALUctrl`=0, `ALUsrc`=0, `ImmOp`=0, `halted`=0, `instret`=0.
- `imem_req` first rises one cycle after reset deassertion (IDLE -> FETCH).
- Minimum 3 cycles per instruction (FETCH, DECODE, EXEC) when `imem_valid` is high in the first FETCH cycle. Each cycle of `imem_valid` delay adds one cycle.
- `EQ` is sampled at the rising edge that ends EXEC. The new `pc` is visible in the following FETCH cycle.
- Register write commits at the rising edge ending EXEC (regfile samples `reg_we`).
- Reset asserted mid-operation (any state) immediately forces reset values. A pending fetch is abandoned and the next fetch is from RESET_PC.

## Configuration
- `CTRL_SEQ_INSTRET_EN` defined:
  - `instret` is a 32-bit register, incremented at the end of every EXEC that completes legally. This includes branches, not-taken branches, and writes to `rd`=0.
  - A misaligned-branch trap does not increment it.
  - Wraps 32'hFFFF_FFFF -> 0.
- Undefined: no counter logic is generated and `instret` is tied to 0. The port is kept so the interface does not change.

## Test plan
- Reset release with `imem_valid`=1 -> `imem_req` high at cycle 1, `pc`=0. Feed ADDI x5,x0,-3 (32'hFFD0_0293) -> EXEC has `ALUsrc`=1, `ImmOp`=32'hFFFF_FFFD, `reg_we`=1, `rd`=5; next `pc`=4.
- ADD x0,x1,x2 (32'h0020_8033) -> `ALUsrc`=0, `reg_we`=0, `ALUctrl`=000; `instret` increments (macro on) or stays 0 (macro off).
- BEQ x1,x2,-8 at pc=0x10 (32'hFE20_8CE3): with `EQ`=1, next `pc`=0x08. With `EQ`=0, next `pc`=0x14. BNE with the same operands inverts both outcomes.
- `imem_valid` delayed 3 cycles -> `imem_req` held 4 cycles, `pc` stable, instruction completes in 6 cycles.
- Illegal word 32'h0000_0000 at pc=0x20 -> HALT, `halted`=1, `pc`=0x20, `imem_req` stays 0 indefinitely. Branch to a target with bit 1 set -> HALT, `pc` unchanged.
- Assert `rst` during FETCH with a pending request -> all outputs return to reset values immediately. After release, the fetch restarts at RESET_PC.
